// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator for WIDTH-bit operands. The captured
// operands are scanned MSB-first, SLICE bits per clock, and the scan stops at
// the first slice that differs. The result is reported as registered
// greater / equal / less flags (o1 / o2 / o3) with a start/done handshake,
// together with the number of slices that were examined.
//
// Optional feature (compile-time macro SEQ_CMP_SIGNED_EN):
//   When defined, an extra input 'sgn' is present. With sgn=1 the operands are
//   treated as two's complement: the MSB of both operands is inverted when they
//   are captured, which turns the unsigned MSB-slice compare into a signed
//   order. With sgn=0, or when the macro is undefined, the compare is unsigned.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1, integer multiple of SLICE)
//   SLICE  bits compared per clock
//   CW     width of cnt, derived from WIDTH/SLICE (not overridable)
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   start  compare request, only sampled while busy=0
//   A, B   operands, captured on the accepted start
//   sgn    (SEQ_CMP_SIGNED_EN only) signed compare select, captured with A/B
//   busy   high from the accepting edge until done drops
//   done   one-cycle pulse, results valid from this cycle on
//   o1     A > B
//   o2     A == B
//   o3     A < B
//   cnt    number of slices examined for the last result
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1,
  localparam int CW = $clog2(WIDTH / SLICE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             o1,
  output logic             o2,
  output logic             o3,
  output logic [CW-1:0]    cnt
);

  localparam int NSLICE = WIDTH / SLICE;
  // Slice index width; at least one bit even for a single-slice scan.
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType          stateReg, stateNext;
  logic [WIDTH-1:0]  aReg, aNext;
  logic [WIDTH-1:0]  bReg, bNext;
  logic [IW-1:0]     idxReg, idxNext;
  logic [CW-1:0]     cntReg, cntNext;
  logic              gtReg, gtNext;
  logic              eqReg, eqNext;
  logic              ltReg, ltNext;

  // Flipping the MSB maps two's complement order onto unsigned order, so the
  // scan itself never needs to know about signedness.
  logic              signFlip;
  logic [WIDTH-1:0]  flipMask;

`ifdef SEQ_CMP_SIGNED_EN
  assign signFlip = sgn;
`else
  assign signFlip = 1'b0;
`endif

  always_comb begin
    flipMask = '0;
    flipMask[WIDTH-1] = signFlip;
  end

  // Split the captured operands into slices; slice gi holds bits
  // [gi*SLICE +: SLICE].
  logic [SLICE-1:0] sliceA [NSLICE];
  logic [SLICE-1:0] sliceB [NSLICE];

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign sliceA[gi] = aReg[gi*SLICE +: SLICE];
      assign sliceB[gi] = bReg[gi*SLICE +: SLICE];
    end
  endgenerate

  // Slice currently under examination (unsigned compare).
  logic [SLICE-1:0] curA;
  logic [SLICE-1:0] curB;
  assign curA = sliceA[idxReg];
  assign curB = sliceB[idxReg];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      idxReg   <= '0;
      cntReg   <= '0;
      gtReg    <= 1'b0;
      eqReg    <= 1'b0;
      ltReg    <= 1'b0;
    end else begin
      stateReg <= stateNext;
      aReg     <= aNext;
      bReg     <= bNext;
      idxReg   <= idxNext;
      cntReg   <= cntNext;
      gtReg    <= gtNext;
      eqReg    <= eqNext;
      ltReg    <= ltNext;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    stateNext = stateReg;
    aNext     = aReg;
    bNext     = bReg;
    idxNext   = idxReg;
    cntNext   = cntReg;
    gtNext    = gtReg;
    eqNext    = eqReg;
    ltNext    = ltReg;

    case (stateReg)
      IDLE: begin
        if (start) begin
          aNext     = A ^ flipMask;
          bNext     = B ^ flipMask;
          idxNext   = IW'(NSLICE - 1);
          cntNext   = '0;
          gtNext    = 1'b0;
          eqNext    = 1'b0;
          ltNext    = 1'b0;
          stateNext = SCAN;
        end
      end

      SCAN: begin
        cntNext = cntReg + CW'(1);
        if (curA > curB) begin
          gtNext    = 1'b1;
          stateNext = DONE;
        end else if (curA < curB) begin
          ltNext    = 1'b1;
          stateNext = DONE;
        end else if (idxReg == '0) begin
          // Every slice matched down to the LSB slice.
          eqNext    = 1'b1;
          stateNext = DONE;
        end else begin
          idxNext = idxReg - IW'(1);
        end
      end

      DONE: begin
        // start is ignored here because busy is still high.
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign busy = (stateReg != IDLE);
  assign done = (stateReg == DONE);
  assign o1   = gtReg;
  assign o2   = eqReg;
  assign o3   = ltReg;
  assign cnt  = cntReg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// Bench for seq_magnitude_comparator. Two instances run side by side on the
// same stimulus: WIDTH=8/SLICE=1 (d1) and WIDTH=8/SLICE=2 (d2).
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       sgn;

  logic       busy1, done1, o1_1, o2_1, o3_1;
  logic [3:0] cnt1;
  logic       busy2, done2, o1_2, o2_2, o3_2;
  logic [2:0] cnt2;

  int passed = 0;
  int total  = 0;

  seq_magnitude_comparator #(.WIDTH(8), .SLICE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SEQ_CMP_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy1),
    .done  (done1),
    .o1    (o1_1),
    .o2    (o2_1),
    .o3    (o3_1),
    .cnt   (cnt1)
  );

  seq_magnitude_comparator #(.WIDTH(8), .SLICE(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SEQ_CMP_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy2),
    .done  (done2),
    .o1    (o1_2),
    .o2    (o2_2),
    .o3    (o3_2),
    .cnt   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: result from plain (signed or unsigned) integer order; slices
  // examined follow from the highest bit where the operands differ.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                input logic s, input int slice,
                                output logic [2:0] f, output int k);
    int ai, bi, top;
    logic [7:0] x;
    if (s) begin
      ai = int'($signed(a));
      bi = int'($signed(b));
    end else begin
      ai = int'(a);
      bi = int'(b);
    end
    f = (ai > bi) ? 3'b100 : ((ai == bi) ? 3'b010 : 3'b001);
    x = a ^ b;
    top = -1;
    for (int i = 0; i < 8; i++) if (x[i]) top = i;
    k = (top < 0) ? (8 / slice) : (8 / slice - top / slice);
  endfunction

  // One compare on both instances. n counts clock edges after the accepting
  // edge; the sample at n is taken in the cycle following edge E(n).
  // pokeAt >= 0 pulses start with different operands in that cycle.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [2:0] e1, input int k1,
                         input logic [2:0] e2, input int k2,
                         input int pokeAt, input string tag);
    logic [2:0] r1, r2, clr1, clr2;
    int lat1, lat2, c1, c2, busyBad1, busyBad2, pulseBad1, pulseBad2;
    logic g1, g2;
    lat1 = -1; lat2 = -1; c1 = -1; c2 = -1;
    r1 = 3'b111; r2 = 3'b111; clr1 = 3'b111; clr2 = 3'b111;
    busyBad1 = 0; busyBad2 = 0; pulseBad1 = 0; pulseBad2 = 0;
    g1 = 1'b0; g2 = 1'b0;

    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);          // must not affect the compare in progress
    B = 8'($urandom);
    sgn = 1'($urandom);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin
        clr1 = {o1_1, o2_1, o3_1};
        clr2 = {o1_2, o2_2, o3_2};
      end
      if (busy1 != (n <= k1)) busyBad1++;
      if (busy2 != (n <= k2)) busyBad2++;
      if (done1) begin
        if (g1) pulseBad1++;
        else begin g1 = 1'b1; lat1 = n; r1 = {o1_1, o2_1, o3_1}; c1 = int'(cnt1); end
      end
      if (done2) begin
        if (g2) pulseBad2++;
        else begin g2 = 1'b1; lat2 = n; r2 = {o1_2, o2_2, o3_2}; c2 = int'(cnt2); end
      end
      if (n == pokeAt) begin
        start = 1'b1; A = 8'h00; B = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end

    chk({tag, ".d1.clear"},   int'(clr1), 0);
    chk({tag, ".d2.clear"},   int'(clr2), 0);
    chk({tag, ".d1.latency"}, lat1, k1);
    chk({tag, ".d2.latency"}, lat2, k2);
    chk({tag, ".d1.flags"},   int'(r1), int'(e1));
    chk({tag, ".d2.flags"},   int'(r2), int'(e2));
    chk({tag, ".d1.cnt"},     c1, k1);
    chk({tag, ".d2.cnt"},     c2, k2);
    chk({tag, ".d1.busy"},    busyBad1, 0);
    chk({tag, ".d2.busy"},    busyBad2, 0);
    chk({tag, ".d1.pulse"},   pulseBad1, 0);
    chk({tag, ".d2.pulse"},   pulseBad2, 0);
    chk({tag, ".d1.hold"},    int'({o1_1, o2_1, o3_1}), int'(e1));
    chk({tag, ".d2.hold"},    int'({o1_2, o2_2, o3_2}), int'(e2));
    $display("cmp %s A=%h B=%h sgn=%0d -> d1 flags=%b cnt=%0d lat=%0d | d2 flags=%b cnt=%0d lat=%0d",
             tag, a, b, s, r1, c1, lat1, r2, c2, lat2);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".d1.busy"},  int'(busy1), 0);
    chk({tag, ".d1.done"},  int'(done1), 0);
    chk({tag, ".d1.flags"}, int'({o1_1, o2_1, o3_1}), 0);
    chk({tag, ".d1.cnt"},   int'(cnt1), 0);
    chk({tag, ".d2.busy"},  int'(busy2), 0);
    chk({tag, ".d2.done"},  int'(done2), 0);
    chk({tag, ".d2.flags"}, int'({o1_2, o2_2, o3_2}), 0);
    chk({tag, ".d2.cnt"},   int'(cnt2), 0);
  endtask

  // Reset asserted in the third SCAN cycle of an equal-operand compare.
  task automatic rst_abort();
    int doneSeen;
    doneSeen = 0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; sgn = 1'b0; start = 1'b1;
    @(negedge clk);            // n=0, first SCAN cycle
    start = 1'b0;
    @(negedge clk);            // n=1
    @(negedge clk);            // n=2, third SCAN cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 || done2) doneSeen++;
    end
    chk("abort.no_done", doneSeen, 0);
    $display("cmp abort A=ff B=ff reset in 3rd SCAN cycle, done pulses after=%0d", doneSeen);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [2:0] e1;
    int         k1;
    logic [2:0] e2;
    int         k2;
    int         poke;
    string      tag;
  } vecType;

  vecType vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    logic [2:0] f1, f2;
    int         m1, m2;

    // Expected flags {o1,o2,o3} and slices examined, worked out by hand.
    vecs.push_back('{8'hA5, 8'h25, 1'b0, 3'b100, 1, 3'b100, 1, -1, "a5_25"});
    vecs.push_back('{8'h5A, 8'h5A, 1'b0, 3'b010, 8, 3'b010, 4,  4, "5a_5a_poke"});
    vecs.push_back('{8'h12, 8'h13, 1'b0, 3'b001, 8, 3'b001, 4, -1, "12_13"});
    vecs.push_back('{8'h03, 8'h01, 1'b0, 3'b100, 7, 3'b100, 4, -1, "b2b_3_1"});
    vecs.push_back('{8'h01, 8'h03, 1'b0, 3'b001, 7, 3'b001, 4, -1, "b2b_1_3"});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 3'b100, 1, 3'b100, 1, -1, "80_01_u"});
    vecs.push_back('{8'h10, 8'h20, 1'b0, 3'b001, 3, 3'b001, 2, -1, "10_20"});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 3'b001, 1, 3'b001, 1,  0, "00_ff_poke"});
    vecs.push_back('{8'hFF, 8'hFE, 1'b0, 3'b100, 8, 3'b100, 4, -1, "ff_fe_u"});
`ifdef SEQ_CMP_SIGNED_EN
    vecs.push_back('{8'h80, 8'h01, 1'b1, 3'b001, 1, 3'b001, 1, -1, "80_01_s"});
    vecs.push_back('{8'hFF, 8'h01, 1'b1, 3'b001, 1, 3'b001, 1, -1, "ff_01_s"});
    vecs.push_back('{8'hFF, 8'hFE, 1'b1, 3'b100, 8, 3'b100, 4, -1, "ff_fe_s"});
`endif

    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; sgn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset");

    foreach (vecs[i])
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e1, vecs[i].k1,
              vecs[i].e2, vecs[i].k2, vecs[i].poke, vecs[i].tag);

    rst_abort();

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      // Bias towards operands that share upper bits so longer scans occur.
      rb = ($urandom_range(0, 2) == 0) ? (ra ^ 8'($urandom_range(0, 15))) : 8'($urandom);
`ifdef SEQ_CMP_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rs, 1, f1, m1);
      model(ra, rb, rs, 2, f2, m2);
      run_cmp(ra, rb, rs, f1, m1, f2, m2, -1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. Scans the operands MSB-first in SLICE-bit slices, one slice per clock, and exits early at the first unequal slice. Returns registered greater/equal/less flags with a start/done handshake. It is the sequential, width-generic successor to the single-bit comparator cell, and per-bit compare logic reuses that cell's gt/eq/lt convention.

Parameters:
WIDTH, 8, operand width in bits; must be >= 1 and an integer multiple of SLICE
SLICE, 1, bits compared per clock; NSLICE = WIDTH/SLICE
CW, $clog2(NSLICE)+1, width of the slice-count output (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a compare; sampled only when busy=0
A  input  WIDTH  operand A, captured on the accepted start
B  input  WIDTH  operand B, captured on the accepted start
busy  output  1  high from the accepting edge until done drops
done  output  1  one-cycle pulse; o1/o2/o3 and cnt are valid from this cycle on
o1  output  1  A > B
o2  output  1  A == B
o3  output  1  A < B
cnt  output  CW  number of slices examined for the last result (1..NSLICE)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-low, on rst_n.
- Reset state: rst_n low at a clk edge forces state IDLE; busy=0, done=0, o1=o2=o3=0, cnt=0; operand registers are cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge: capture A and B, set slice index idx=NSLICE-1, cnt=0, clear o1/o2/o3 to 0, go to SCAN.
  - start=0: hold state; previous results stay stable.
- SCAN, once per cycle: compare slice idx (bits [idx*SLICE +: SLICE]) as unsigned values.
  - A slice > B slice: set o1=1, go to DONE.
  - A slice < B slice: set o3=1, go to DONE.
  - Slices equal and idx==0: set o2=1, go to DONE.
  - Slices equal and idx>0: decrement idx, stay in SCAN.
  - cnt increments on every SCAN edge.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE. o1/o2/o3/cnt hold until the next accepted start.
- Result encoding: exactly one of o1/o2/o3 is 1 after any completed compare; all are 0 from reset until the first done.
- Latency: if the start edge is E0 and k slices are examined, done is high in the cycle following edge Ek. Range is k=1 (MSB slice differs) to k=NSLICE (operands equal).
- start while busy=1 (SCAN or DONE): ignored, not queued.
- start high in the DONE cycle: ignored, because busy=1. A new start is accepted from the following IDLE cycle.
- A/B changing after capture: no effect on the compare in progress.
- rst_n low mid-SCAN or in DONE: abort. Next cycle is IDLE with all outputs at reset values; no done pulse.
- WIDTH==SLICE: single-cycle scan, k=1 always.

Optional Feature:
- Macro: SEQ_CMP_SIGNED_EN.
- Defined: adds input port sgn (1 bit), captured with A/B on start.
  - sgn=1: operands are two's complement. The most-significant bit of each operand is inverted before the compare, so the MSB slice compare yields the signed order. All other slices are unchanged.
  - sgn=0: identical to unsigned operation.
- Undefined: sgn port is absent; comparison is always unsigned.

Test Plan:
- Reset, then WIDTH=8/SLICE=1, A=8'hA5, B=8'h25: o1=1, o2=0, o3=0, cnt=1; done one cycle after the start edge.
- WIDTH=8/SLICE=1, A=8'h5A, B=8'h5A: o2=1, cnt=8, done 8 cycles after start; start pulsed during SCAN is ignored and cnt stays 8.
- WIDTH=8/SLICE=2, A=8'h12, B=8'h13: o3=1, cnt=4; busy high for 5 cycles including the DONE cycle.
- Two back-to-back compares, A=3/B=1 then A=1/B=3: first result o1=1 holds through IDLE. o1/o2/o3 clear on the second accepted start, then o3=1.
- rst_n low in the 3rd SCAN cycle of A=8'hFF, B=8'hFF: next cycle busy=0, done=0, o1=o2=o3=0, cnt=0; no done pulse follows.
- With SEQ_CMP_SIGNED_EN, sgn=1, A=8'h80 (-128), B=8'h01: o3=1, cnt=1. Same operands with sgn=0: o1=1.
